// File: rtl/axi_hs_buffer.sv
// axi_hs_buffer: valid/ready handshake buffer with a DEPTH-entry FIFO between
// an upstream master and a downstream slave. Zero-valued beats can optionally
// be swallowed, and saturating beat/drop counters are kept for debug.
// s_ready and m_valid come from registered state only, so neither side sees
// a combinational path from the other side's handshake inputs.
module axi_hs_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_ZERO  = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  input  logic                    m_ready,
  input  logic                    clear_cnt,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t                  state;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic accept;
  logic zero_beat;
  logic push;
  logic pop;
  logic drop;

  assign s_ready = (state != FULL);
  assign m_valid = (state != EMPTY);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Handshake decode: an accepted zero beat completes but is not stored when dropping is enabled
  always_comb begin
    accept    = s_valid && s_ready;
    zero_beat = (DROP_ZERO != 0) && (s_data == '0);
    push      = accept && !zero_beat;
    drop      = accept && zero_beat;
    pop       = m_valid && m_ready;
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Occupancy FSM with pointers and level; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      case (state)
        EMPTY: begin
          if (push) begin
            state <= PARTIAL;
          end
        end
        PARTIAL: begin
          if (push && !pop && (level == LW'(DEPTH - 1))) begin
            state <= FULL;
          end else if (pop && !push && (level == LW'(1))) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state <= PARTIAL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating debug counters; a synchronous clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else if (clear_cnt) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_hs_buffer.sv
// Bench for axi_hs_buffer: three instances (plain, zero-dropping, 4-bit
// counters) with per-instance scoreboard queues. Inputs change 1 time unit
// after the rising edge; handshakes are observed on the falling edge.
module tb_axi_hs_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        sv0, mr0, clr0, sr0, mv0;
  logic [31:0] sd0, md0;
  logic [2:0]  lv0;
  logic [15:0] bc0, dc0;

  logic        sv1, mr1, clr1, sr1, mv1;
  logic [31:0] sd1, md1;
  logic [2:0]  lv1;
  logic [15:0] bc1, dc1;

  logic        sv2, mr2, clr2, sr2, mv2;
  logic [31:0] sd2, md2;
  logic [2:0]  lv2;
  logic [3:0]  bc2, dc2;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;

  axi_hs_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ZERO(0), .CNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .s_valid(sv0), .s_data(sd0), .s_ready(sr0),
    .m_valid(mv0), .m_data(md0), .m_ready(mr0), .clear_cnt(clr0),
    .level(lv0), .beat_cnt(bc0), .drop_cnt(dc0));

  axi_hs_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ZERO(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .reset(reset), .s_valid(sv1), .s_data(sd1), .s_ready(sr1),
    .m_valid(mv1), .m_data(md1), .m_ready(mr1), .clear_cnt(clr1),
    .level(lv1), .beat_cnt(bc1), .drop_cnt(dc1));

  axi_hs_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ZERO(0), .CNT_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .s_valid(sv2), .s_data(sd2), .s_ready(sr2),
    .m_valid(mv2), .m_data(md2), .m_ready(mr2), .clear_cnt(clr2),
    .level(lv2), .beat_cnt(bc2), .drop_cnt(dc2));

  // Scoreboard for u0: expected beats enter on accepted input, leave on output handshake
  always @(negedge clk) begin
    if (reset) begin
      if (mv0 && mr0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL u0_unexpected_beat got %h required none", md0);
        end else begin
          e0 = q0.pop_front();
          if (md0 !== e0) begin
            errors++;
            $display("FAIL u0_data got %h required %h", md0, e0);
          end
        end
      end
      if (sv0 && sr0) q0.push_back(sd0);
    end
  end

  // Scoreboard for u1: zero beats are accepted but never expected at the output
  always @(negedge clk) begin
    if (reset) begin
      if (mv1 && mr1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL u1_unexpected_beat got %h required none", md1);
        end else begin
          e1 = q1.pop_front();
          if (md1 !== e1) begin
            errors++;
            $display("FAIL u1_data got %h required %h", md1, e1);
          end
        end
      end
      if (sv1 && sr1 && (sd1 != 32'd0)) q1.push_back(sd1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    {sv0, mr0, clr0, sv1, mr1, clr1, sv2, mr2, clr2} = '0;
    sd0 = '0; sd1 = '0; sd2 = '0;
    repeat (2) tick();
    checks++;
    if ({lv0, mv0, sr0, md0} !== {3'd0, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_outputs got %h required %h", {lv0, mv0, sr0, md0}, {3'd0, 1'b0, 1'b1, 32'd0});
    end
    checks++;
    if ({bc0, dc0, bc1, dc1, bc2, dc2} !== '0) begin
      errors++;
      $display("FAIL reset_counters got %h required 0", {bc0, dc0, bc1, dc1, bc2, dc2});
    end
    reset = 1'b1;
    tick();
    sv0 = 1'b1; sd0 = 32'hDEAD0001; tick();
    sd0 = 32'hDEAD0002; tick();
    sv0 = 1'b0;
    checks++;
    if (lv0 !== 3'd2) begin
      errors++;
      $display("FAIL midrun_level got %0d required 2", lv0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({lv0, mv0, sr0} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrun_reset got %h required %h", {lv0, mv0, sr0}, {3'd0, 1'b0, 1'b1});
    end
    q0.delete();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_fill;
    mr0 = 1'b0;
    sv0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd0 = 32'(32'h11 * (i + 1));
      tick();
      checks++;
      if (lv0 !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_level got %0d required %0d", lv0, i + 1);
      end
    end
    sv0 = 1'b0;
    checks++;
    if ({sr0, mv0, md0} !== {1'b0, 1'b1, 32'h11}) begin
      errors++;
      $display("FAIL fill_full got %h required %h", {sr0, mv0, md0}, {1'b0, 1'b1, 32'h11});
    end
  endtask

  task automatic test_drain_wrap;
    bit acc = 1'b0;
    mr0 = 1'b1;
    sd0 = 32'h55;
    sv0 = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) begin
      @(negedge clk);
      acc = sr0;
      tick();
    end
    sv0 = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL drain_accept_timeout got 0 required 1");
    end
    for (int n = 0; n < 20 && lv0 != 3'd0; n++) tick();
    checks++;
    if ({lv0, mv0, md0} !== {3'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL drain_empty got %h required %h", {lv0, mv0, md0}, {3'd0, 1'b0, 32'd0});
    end
    checks++;
    if (bc0 !== 16'd5) begin
      errors++;
      $display("FAIL drain_beat_cnt got %0d required 5", bc0);
    end
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain_missing_beats got %0d required 0", q0.size());
    end
  endtask

  task automatic test_back_to_back;
    mr0 = 1'b0;
    sv0 = 1'b1;
    sd0 = 32'h100; tick();
    sd0 = 32'h101; tick();
    checks++;
    if (lv0 !== 3'd2) begin
      errors++;
      $display("FAIL b2b_prefill got %0d required 2", lv0);
    end
    mr0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sd0 = 32'(32'h102 + i);
      tick();
      checks++;
      if (lv0 !== 3'd2) begin
        errors++;
        $display("FAIL b2b_level got %0d required 2", lv0);
      end
    end
    sv0 = 1'b0;
    checks++;
    if (bc0 !== 16'd15) begin
      errors++;
      $display("FAIL b2b_beat_cnt got %0d required 15", bc0);
    end
    for (int n = 0; n < 20 && lv0 != 3'd0; n++) tick();
    checks++;
    if ({lv0, bc0} !== {3'd0, 16'd17}) begin
      errors++;
      $display("FAIL b2b_drain got %h required %h", {lv0, bc0}, {3'd0, 16'd17});
    end
  endtask

  task automatic test_drop_zero;
    mr0 = 1'b1;
    mr1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sd0 = (i == 1) ? 32'hA5 : 32'h0;
      sd1 = (i == 1) ? 32'hA5 : 32'h0;
      sv0 = 1'b1;
      sv1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({sr0, sr1} !== 2'b11) begin
        errors++;
        $display("FAIL drop_s_ready got %b required 11", {sr0, sr1});
      end
      tick();
    end
    sv0 = 1'b0;
    sv1 = 1'b0;
    repeat (4) tick();
    checks++;
    if ({dc1, bc1, lv1} !== {16'd2, 16'd1, 3'd0}) begin
      errors++;
      $display("FAIL drop_u1_counts got %h required %h", {dc1, bc1, lv1}, {16'd2, 16'd1, 3'd0});
    end
    checks++;
    if ({dc0, bc0, lv0} !== {16'd0, 16'd20, 3'd0}) begin
      errors++;
      $display("FAIL nodrop_u0_counts got %h required %h", {dc0, bc0, lv0}, {16'd0, 16'd20, 3'd0});
    end
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drop_missing_beats got %0d required 0", q0.size() + q1.size());
    end
    mr0 = 1'b0;
    mr1 = 1'b0;
  endtask

  task automatic test_saturation;
    mr2 = 1'b1;
    sv2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sd2 = 32'(i + 1);
      tick();
    end
    sv2 = 1'b0;
    for (int n = 0; n < 20 && lv2 != 3'd0; n++) tick();
    checks++;
    if ({lv2, bc2} !== {3'd0, 4'hF}) begin
      errors++;
      $display("FAIL sat_beat_cnt got %h required %h", {lv2, bc2}, {3'd0, 4'hF});
    end
    mr2 = 1'b0;
    sv2 = 1'b1;
    sd2 = 32'h77;
    tick();
    sv2 = 1'b0;
    checks++;
    if ({lv2, bc2, md2} !== {3'd1, 4'hF, 32'h77}) begin
      errors++;
      $display("FAIL sat_hold got %h required %h", {lv2, bc2, md2}, {3'd1, 4'hF, 32'h77});
    end
    mr2 = 1'b1;
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    mr2 = 1'b0;
    checks++;
    if ({lv2, bc2, dc2} !== {3'd0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL clear_priority got %h required %h", {lv2, bc2, dc2}, {3'd0, 4'h0, 4'h0});
    end
  endtask

  task automatic test_async_reset_full;
    mr0 = 1'b0;
    sv0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd0 = 32'(32'hC0 + i);
      tick();
    end
    sv0 = 1'b0;
    checks++;
    if ({lv0, sr0} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL async_prefill got %h required %h", {lv0, sr0}, {3'd4, 1'b0});
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({mv0, lv0, sr0, md0} !== {1'b0, 3'd0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL async_reset got %h required %h", {mv0, lv0, sr0, md0}, {1'b0, 3'd0, 1'b1, 32'd0});
    end
    q0.delete();
    mr0 = 1'b1;
    #1;
    reset = 1'b1;
    repeat (5) tick();
    checks++;
    if ({mv0, lv0, bc0} !== {1'b0, 3'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_after got %h required %h", {mv0, lv0, bc0}, {1'b0, 3'd0, 16'd0});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_drop_zero();
    test_saturation();
    test_async_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_hs_buffer.md
Name: axi_hs_buffer

Overview:
Parametrised valid/ready handshake buffer that sits between a data master and a slave on the point-to-point AXI-style channel. It decouples the two sides with a DEPTH-entry FIFO and is generic in data width. It optionally discards all-zero beats while still completing the handshake. It keeps saturating beat and drop counters for debug and verification.

Parameters:
DATA_WIDTH, 32, width of the data path in bits.
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
DROP_ZERO, 0, 1 means an accepted beat with s_data==0 completes the handshake but is not stored.
CNT_WIDTH, 16, width of beat_cnt and drop_cnt.

Ports:
clk  input  1  rising-edge clock for all state.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
s_valid  input  1  upstream beat valid.
s_data  input  DATA_WIDTH  upstream beat data.
s_ready  output  1  buffer can accept a beat this cycle.
m_valid  output  1  buffer holds a beat for downstream.
m_data  output  DATA_WIDTH  head-of-FIFO data.
m_ready  input  1  downstream accepts the head beat.
clear_cnt  input  1  synchronous clear of beat_cnt and drop_cnt.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
beat_cnt  output  CNT_WIDTH  count of completed downstream handshakes, saturating.
drop_cnt  output  CNT_WIDTH  count of zero beats discarded, saturating.

Behaviour:
- Reset (reset==0, asynchronous): wr_ptr, rd_ptr, level, beat_cnt and drop_cnt go to 0; state goes to EMPTY; m_valid=0, m_data=0, s_ready=1. Memory contents are not reset. Reset asserted mid-transfer discards all buffered beats, and m_valid falls without waiting for a clock edge.
- Reset release: the first edge with reset==1 is a normal cycle.
- Push: s_valid && s_ready at a rising edge.
  - The beat is written at wr_ptr, wr_ptr advances modulo DEPTH and level increments.
  - Exception: with DROP_ZERO=1 and s_data==0 the beat is not written, pointers and level are unchanged, and drop_cnt increments.
- Pop: m_valid && m_ready at a rising edge. rd_ptr advances modulo DEPTH, level decrements and beat_cnt increments.
- State is derived from the registered level:
  - EMPTY: level==0.
  - PARTIAL: 0<level<DEPTH.
  - FULL: level==DEPTH.
- State transitions:
  - EMPTY->PARTIAL on a stored push.
  - PARTIAL->FULL on a stored push without a pop when level==DEPTH-1.
  - FULL->PARTIAL on a pop.
  - PARTIAL->EMPTY on a pop without a stored push when level==1.
- Outputs are functions of registers only, so there is no combinational path from s_valid to s_ready or from m_ready to m_valid:
  - s_ready = (state != FULL).
  - m_valid = (state != EMPTY).
  - m_data = mem[rd_ptr] when m_valid, else 0.
- Latency: a beat stored at edge N appears on m_valid/m_data after edge N. Pass-through latency is 1 cycle, and there is no empty-bypass.
- Simultaneous push and pop in PARTIAL: both occur and level is unchanged.
- In FULL: s_ready=0, so there is no push even if a pop happens in the same cycle. s_ready rises in the cycle after the pop.
- In EMPTY: a pop cannot occur and m_ready is ignored.
- Stored beats drain in FIFO order; pointer wrap is modulo DEPTH.
- With DROP_ZERO=0, zero-valued beats are stored like any other beat.
- Counters:
  - Both saturate at all-ones and do not wrap.
  - clear_cnt==1 at an edge sets both counters to 0; clear takes priority over a same-cycle increment.
  - The FIFO is unaffected by clear_cnt.
- Master-side rule: once s_valid is asserted it is held until accepted, with s_data stable. The buffer does not check this.

Test Plan:
- Reset and fill: DEPTH=4. Assert reset=0 mid-run, then release. Push 0x11,0x22,0x33,0x44 with m_ready=0. Expect level 1,2,3,4; s_ready=0 after the 4th edge; m_data=0x11.
- Drain order with wrap: continuing from the fill, hold m_ready=1 and push 0x55 once s_ready rises. Expect outputs 0x11,0x22,0x33,0x44,0x55 in order; beat_cnt=5; level returns to 0; m_data=0.
- Simultaneous push/pop: level=2 with s_valid=m_ready=1 for 10 cycles on incrementing data. Expect level to stay at 2, in-order output, and beat_cnt +10.
- DROP_ZERO=1: send 0x0,0xA5,0x0. Expect s_ready=1 on all three, only 0xA5 emerging, drop_cnt=2, beat_cnt=1. With DROP_ZERO=0 the same stimulus yields 3 output beats.
- Counter saturation and clear: CNT_WIDTH=4, pass 20 beats. Expect beat_cnt=15 (saturated). Then assert clear_cnt in the same cycle as a pop; expect beat_cnt=0.
- Async reset in FULL: with level=4, drive reset=0 between clock edges. Expect m_valid=0, level=0 and s_ready=1 before the next edge, with no further output beats.
